// File: rtl/alu_sys_pkg.sv
// Shared definitions for the UART-driven ALU subsystem: bus widths, the ALU
// command byte, controller state encoding and ALU function codes.
package alu_sys_pkg;

   localparam int         DATA_W          = 8;
   localparam int         FUN_W           = 4;
   localparam int         OUT_W           = 16;
   localparam logic [7:0] CMD_ALU_DEF     = 8'hCC;
   localparam int         TIMEOUT_CYC_DEF = 1023;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GET_A    = 3'd1,
      ST_GET_B    = 3'd2,
      ST_GET_FUN  = 3'd3,
      ST_ALU_REQ  = 3'd4,
      ST_ALU_WAIT = 3'd5,
      ST_TX_LSB   = 3'd6,
      ST_TX_MSB   = 3'd7
   } ctrl_state_t;

   localparam logic [3:0] ALU_FUN_ADD   = 4'h0;
   localparam logic [3:0] ALU_FUN_SUB   = 4'h1;
   localparam logic [3:0] ALU_FUN_MUL   = 4'h2;
   localparam logic [3:0] ALU_FUN_DIV   = 4'h3;
   localparam logic [3:0] ALU_FUN_AND   = 4'h4;
   localparam logic [3:0] ALU_FUN_OR    = 4'h5;
   localparam logic [3:0] ALU_FUN_NAND  = 4'h6;
   localparam logic [3:0] ALU_FUN_NOR   = 4'h7;
   localparam logic [3:0] ALU_FUN_XOR   = 4'h8;
   localparam logic [3:0] ALU_FUN_XNOR  = 4'h9;
   localparam logic [3:0] ALU_FUN_CMPEQ = 4'hA;
   localparam logic [3:0] ALU_FUN_CMPGT = 4'hB;
   localparam logic [3:0] ALU_FUN_CMPLT = 4'hC;
   localparam logic [3:0] ALU_FUN_SHR   = 4'hD;
   localparam logic [3:0] ALU_FUN_SHL   = 4'hE;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Command controller between UART RX/TX and the ALU: parses CMD,A,B,FUN frames,
// pulses ALU_EN and returns the result LSB first. Optional timeout: ALU_CTRL_TIMEOUT_EN.
module alu_cmd_ctrl
   import alu_sys_pkg::*;
#(
   parameter int                    DATA_WIDTH  = DATA_W,
   parameter int                    FUN_WIDTH   = FUN_W,
   parameter int                    OUT_WIDTH   = OUT_W,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU     = DATA_WIDTH'(CMD_ALU_DEF),
   parameter int                    TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic [OUT_WIDTH-1:0]  ALU_OUT,
   input  logic                  OUT_VLD,
   input  logic                  TX_BUSY,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] B,
   output logic [FUN_WIDTH-1:0]  ALU_FUN,
   output logic                  ALU_EN,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  CTRL_BUSY,
   output logic                  FRAME_ERR
);

   if (OUT_WIDTH != 2 * DATA_WIDTH || FUN_WIDTH > DATA_WIDTH || TIMEOUT_CYC < 2) begin : g_bad_params
      $error("alu_cmd_ctrl: need OUT_WIDTH == 2*DATA_WIDTH, FUN_WIDTH <= DATA_WIDTH, TIMEOUT_CYC >= 2");
   end

   ctrl_state_t           r_state;
   ctrl_state_t           w_state_next;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [FUN_WIDTH-1:0]  r_fun;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic [DATA_WIDTH-1:0] r_res_msb;
   logic                  r_alu_en;
   logic                  r_tx_vld;
   logic                  r_busy;
   logic                  w_ld_a;
   logic                  w_ld_b;
   logic                  w_ld_fun;
   logic                  w_capture;
   logic                  w_tmo_hit;

`ifdef ALU_CTRL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_frame_err;
   logic             w_in_get;

   assign w_in_get  = (r_state == ST_GET_A) || (r_state == ST_GET_B) || (r_state == ST_GET_FUN);
   // A byte arriving on the expiry cycle takes priority over the timeout.
   assign w_tmo_hit = w_in_get && !RX_D_VLD && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmo_cnt   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_tmo_hit;
         if (!w_in_get || RX_D_VLD || w_tmo_hit) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end
      end
   end

   assign FRAME_ERR = r_frame_err;
`else
   assign w_tmo_hit = 1'b0;
   assign FRAME_ERR = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      w_ld_a       = 1'b0;
      w_ld_b       = 1'b0;
      w_ld_fun     = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (RX_D_VLD && (RX_P_DATA == CMD_ALU)) w_state_next = ST_GET_A;
         end
         ST_GET_A: begin
            if (RX_D_VLD) begin
               w_ld_a       = 1'b1;
               w_state_next = ST_GET_B;
            end else if (w_tmo_hit) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_GET_B: begin
            if (RX_D_VLD) begin
               w_ld_b       = 1'b1;
               w_state_next = ST_GET_FUN;
            end else if (w_tmo_hit) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_GET_FUN: begin
            if (RX_D_VLD) begin
               w_ld_fun     = 1'b1;
               w_state_next = ST_ALU_REQ;
            end else if (w_tmo_hit) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_ALU_REQ:  w_state_next = ST_ALU_WAIT;
         ST_ALU_WAIT: begin
            if (OUT_VLD) begin
               w_capture    = 1'b1;
               w_state_next = ST_TX_LSB;
            end
         end
         ST_TX_LSB:   if (!TX_BUSY) w_state_next = ST_TX_MSB;
         ST_TX_MSB:   if (!TX_BUSY) w_state_next = ST_IDLE;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   // Output registers are decoded from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_fun     <= '0;
         r_tx_data <= '0;
         r_res_msb <= '0;
         r_alu_en  <= 1'b0;
         r_tx_vld  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_alu_en <= (w_state_next == ST_ALU_REQ);
         r_tx_vld <= (w_state_next == ST_TX_LSB) || (w_state_next == ST_TX_MSB);
         r_busy   <= (w_state_next != ST_IDLE);
         if (w_ld_a)   r_a   <= RX_P_DATA;
         if (w_ld_b)   r_b   <= RX_P_DATA;
         if (w_ld_fun) r_fun <= RX_P_DATA[FUN_WIDTH-1:0];
         if (w_capture) begin
            r_res_msb <= ALU_OUT[OUT_WIDTH-1:DATA_WIDTH];
            r_tx_data <= ALU_OUT[DATA_WIDTH-1:0];
         end else if ((r_state == ST_TX_LSB) && !TX_BUSY) begin
            r_tx_data <= r_res_msb;
         end
      end
   end

   assign A         = r_a;
   assign B         = r_b;
   assign ALU_FUN   = r_fun;
   assign ALU_EN    = r_alu_en;
   assign TX_P_DATA = r_tx_data;
   assign TX_D_VLD  = r_tx_vld;
   assign CTRL_BUSY = r_busy;

endmodule
